// File: rtl/ddr2pbuf_nb_if.sv
// Bus bundle for ddr2pbuf_nb: start/done and config, ddr1/ddr2 beat streams, 4-bank pbuf write port.
// Master drives the streams and config; slave (the writer) owns done, the pbuf port and err.
interface ddr2pbuf_nb_if #(
  parameter int ADDR_W = 8,
  parameter int DDR_W  = 64,
  parameter int CH_W   = 4,
  parameter int PIX_W  = 4,
  parameter int ROW_W  = 2
);
  logic                   start;
  logic                   done;
  logic [7:0]             conf_trans_num;
  logic [2:0]             conf_mode;
  logic [CH_W-1:0]        conf_ch_num;
  logic [PIX_W-1:0]       conf_pix_num;
  logic [ROW_W-1:0]       conf_row_num;
  logic [DDR_W-1:0]       ddr1_data;
  logic                   ddr1_valid;
  logic [DDR_W-1:0]       ddr2_data;
  logic                   ddr2_valid;
  logic [3:0][ADDR_W-1:0] pbuf_wr_addr;
  logic [3:0][DDR_W-1:0]  pbuf_wr_data;
  logic [3:0]             pbuf_wr_en;
  logic                   err;

  modport master (
    output start, conf_trans_num, conf_mode, conf_ch_num, conf_pix_num, conf_row_num,
    output ddr1_data, ddr1_valid, ddr2_data, ddr2_valid,
    input  done, pbuf_wr_addr, pbuf_wr_data, pbuf_wr_en, err
  );

  modport slave (
    input  start, conf_trans_num, conf_mode, conf_ch_num, conf_pix_num, conf_row_num,
    input  ddr1_data, ddr1_valid, ddr2_data, ddr2_valid,
    output done, pbuf_wr_addr, pbuf_wr_data, pbuf_wr_en, err
  );
endinterface

// File: rtl/ddr2pbuf_nb.sv
// DDR-to-pbuf writer (FWD/BWD/UPD) with optional sticky err under DDR2PBUF_ERR_EN.
// Latency: write 1 cycle after beat, done 2 cycles after last beat; no backpressure, beats in RUN always taken.
module ddr2pbuf_nb #(
  parameter int BUF_DEPTH = 256,
  parameter int ADDR_W    = $clog2(BUF_DEPTH),
  parameter int DATA_W    = 16,
  parameter int BATCH     = 4,
  parameter int CH_W      = 4,
  parameter int PIX_W     = 4,
  parameter int ROW_W     = 2
) (
  input logic          clk,
  input logic          rst,
  ddr2pbuf_nb_if.slave bus
);
  localparam int DDR_W  = DATA_W * BATCH;
  localparam int UPD_AW = CH_W + ROW_W + PIX_W - 2;

  localparam logic [2:0] MODE_FWD = 3'd0;
  localparam logic [2:0] MODE_BWD = 3'd1;
  localparam logic [2:0] MODE_UPD = 3'd2;

  // FLUSH covers the cycle the last write is on the pbuf port, so done lands one cycle later.
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             mode_q, mode_d;
  logic [7:0]             trans_num_q, trans_num_d;
  logic [CH_W-1:0]        ch_num_q, ch_num_d;
  logic [PIX_W-1:0]       pix_num_q, pix_num_d;
  logic [ROW_W-1:0]       row_num_q, row_num_d;
  logic [7:0]             beat_q, beat_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [PIX_W-1:0]       pix_q, pix_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [3:0]             wr_en_q, wr_en_d;
  logic [3:0][ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [3:0][DDR_W-1:0]  wr_data_q, wr_data_d;
  logic                   done_q, done_d;

  logic                   str_vld;
  logic                   beat_acc;
  logic                   last_beat;
  logic [1:0]             bwd_bank;
  logic [1:0]             upd_bank;
  logic [UPD_AW-1:0]      upd_addr;

  always_comb begin
    str_vld = 1'b0;
    case (mode_q)
      MODE_FWD: str_vld = bus.ddr2_valid;
      MODE_BWD: str_vld = bus.ddr2_valid;
      MODE_UPD: str_vld = bus.ddr1_valid;
      default:  str_vld = 1'b0;
    endcase
  end

  assign beat_acc  = (state_q == ST_RUN) && str_vld;
  assign last_beat = (mode_q == MODE_UPD) ?
                     ((ch_q == ch_num_q) && (pix_q == pix_num_q) && (row_q == row_num_q)) :
                     (beat_q == trans_num_q);
  assign bwd_bank  = beat_q[1:0];
  assign upd_bank  = {row_q[0], pix_q[0]};
  assign upd_addr  = {ch_q, row_q[ROW_W-1:1], pix_q[PIX_W-1:1]};

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    trans_num_d = trans_num_q;
    ch_num_d    = ch_num_q;
    pix_num_d   = pix_num_q;
    row_num_d   = row_num_q;
    beat_d      = beat_q;
    ch_d        = ch_q;
    pix_d       = pix_q;
    row_d       = row_q;
    wr_en_d     = 4'b0000;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mode_d      = bus.conf_mode;
          trans_num_d = bus.conf_trans_num;
          ch_num_d    = bus.conf_ch_num;
          pix_num_d   = bus.conf_pix_num;
          row_num_d   = bus.conf_row_num;
          beat_d      = '0;
          ch_d        = '0;
          pix_d       = '0;
          row_d       = '0;
          state_d     = (bus.conf_mode <= MODE_UPD) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (beat_acc) begin
          case (mode_q)
            MODE_FWD: begin
              wr_en_d = 4'b1111;
              for (int b = 0; b < 4; b++) begin
                wr_addr_d[b] = ADDR_W'(beat_q);
                wr_data_d[b] = bus.ddr2_data;
              end
            end
            MODE_BWD: begin
              wr_en_d[bwd_bank]   = 1'b1;
              wr_addr_d[bwd_bank] = ADDR_W'(beat_q >> 2);
              wr_data_d[bwd_bank] = bus.ddr2_data;
            end
            MODE_UPD: begin
              wr_en_d[upd_bank]   = 1'b1;
              wr_addr_d[upd_bank] = ADDR_W'(upd_addr);
              wr_data_d[upd_bank] = bus.ddr1_data;
            end
            default: ;
          endcase

          // UPD walks ch fastest, then pix, then row; FWD/BWD just count beats.
          if (mode_q == MODE_UPD) begin
            if (ch_q == ch_num_q) begin
              ch_d = '0;
              if (pix_q == pix_num_q) begin
                pix_d = '0;
                row_d = row_q + 1'b1;
              end else begin
                pix_d = pix_q + 1'b1;
              end
            end else begin
              ch_d = ch_q + 1'b1;
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end

          if (last_beat) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      trans_num_q <= '0;
      ch_num_q    <= '0;
      pix_num_q   <= '0;
      row_num_q   <= '0;
      beat_q      <= '0;
      ch_q        <= '0;
      pix_q       <= '0;
      row_q       <= '0;
      wr_en_q     <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      trans_num_q <= trans_num_d;
      ch_num_q    <= ch_num_d;
      pix_num_q   <= pix_num_d;
      row_num_q   <= row_num_d;
      beat_q      <= beat_d;
      ch_q        <= ch_d;
      pix_q       <= pix_d;
      row_q       <= row_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
    end
  end

  assign bus.pbuf_wr_en   = wr_en_q;
  assign bus.pbuf_wr_addr = wr_addr_q;
  assign bus.pbuf_wr_data = wr_data_q;
  assign bus.done         = done_q;

`ifdef DDR2PBUF_ERR_EN
  logic err_q, err_d;

  // Protocol violations: stray beats on the active stream outside RUN, or a restart mid-transfer.
  always_comb begin
    err_d = err_q;
    if ((state_q != ST_RUN) && str_vld) err_d = 1'b1;
    if ((state_q == ST_RUN) && bus.start) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_ddr2pbuf_nb.sv
// Randomized scoreboard bench for ddr2pbuf_nb: arithmetic reference model feeds expected writes/dones.
module tb_ddr2pbuf_nb;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int BATCH  = 4;
  localparam int DDR_W  = DATA_W * BATCH;
  localparam int CH_W   = 4;
  localparam int PIX_W  = 4;
  localparam int ROW_W  = 2;
`ifdef DDR2PBUF_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  ddr2pbuf_nb_if #(.ADDR_W(ADDR_W), .DDR_W(DDR_W), .CH_W(CH_W), .PIX_W(PIX_W), .ROW_W(ROW_W)) bus ();

  ddr2pbuf_nb #(
    .BUF_DEPTH(256), .DATA_W(DATA_W), .BATCH(BATCH),
    .CH_W(CH_W), .PIX_W(PIX_W), .ROW_W(ROW_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                     cyc;
    logic [3:0]             en;
    logic [3:0][ADDR_W-1:0] addr;
    logic [3:0][DDR_W-1:0]  data;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  bit  err_exp = 1'b0;
  logic [3:0][ADDR_W-1:0] m_addr = '0;
  logic [3:0][DDR_W-1:0]  m_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write or done the DUT presents must match the head of its queue.
  always @(negedge clk) begin
    wr_t e;
    int  dc;
    if (bus.pbuf_wr_en != 4'b0000) begin
      if (wq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got en=%b want none (cyc %0d)", bus.pbuf_wr_en, cyc);
      end else begin
        e = wq.pop_front();
        chk("wr_cyc", 64'(cyc), 64'(e.cyc));
        chk("wr_en", 64'(bus.pbuf_wr_en), 64'(e.en));
        for (int b = 0; b < 4; b++) begin
          chk("wr_addr", 64'(bus.pbuf_wr_addr[b]), 64'(e.addr[b]));
          chk("wr_data", bus.pbuf_wr_data[b], e.data[b]);
        end
      end
    end
    if (bus.done) begin
      done_cnt++;
      if (dq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want 0 (cyc %0d)", cyc);
      end else begin
        dc = dq.pop_front();
        chk("done_cyc", 64'(cyc), 64'(dc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: beat k of a transfer lands where the mode's addressing rule puts it.
  task automatic model_push(input logic [2:0] mode, input int k, input int cn, input int pn,
                            input logic [DDR_W-1:0] d, input int at);
    wr_t e;
    int  ch, pix, row, bnk, a;
    e.cyc = at;
    e.en  = 4'b0000;
    if (mode == 3'd0) begin
      for (int b = 0; b < 4; b++) begin
        m_addr[b] = ADDR_W'(k % 256);
        m_data[b] = d;
      end
      e.en = 4'b1111;
    end else if (mode == 3'd1) begin
      bnk = k % 4;
      m_addr[bnk] = ADDR_W'((k / 4) % 256);
      m_data[bnk] = d;
      e.en[bnk] = 1'b1;
    end else begin
      ch  = k % (cn + 1);
      pix = (k / (cn + 1)) % (pn + 1);
      row = k / ((cn + 1) * (pn + 1));
      bnk = (row % 2) * 2 + (pix % 2);
      a   = ch * (1 << (ROW_W + PIX_W - 2)) + (row / 2) * (1 << (PIX_W - 1)) + pix / 2;
      m_addr[bnk] = ADDR_W'(a % 256);
      m_data[bnk] = d;
      e.en[bnk] = 1'b1;
    end
    e.addr = m_addr;
    e.data = m_data;
    wq.push_back(e);
  endtask

  task automatic noise(input logic [2:0] mode);
    if (mode == 3'd2) begin
      bus.ddr2_valid = 1'($urandom_range(0, 1));
      bus.ddr2_data  = {$urandom, $urandom};
    end else begin
      bus.ddr1_valid = 1'($urandom_range(0, 1));
      bus.ddr1_data  = {$urandom, $urandom};
    end
  endtask

  task automatic drive_beat(input logic [2:0] mode, input int k, input int cn, input int pn,
                            input int nb, input bit expect_it);
    logic [DDR_W-1:0] d;
    d = {$urandom, $urandom};
    noise(mode);
    if (mode == 3'd2) begin
      bus.ddr1_valid = 1'b1;
      bus.ddr1_data  = d;
    end else begin
      bus.ddr2_valid = 1'b1;
      bus.ddr2_data  = d;
    end
    if (expect_it) begin
      model_push(mode, k, cn, pn, d, cyc + 1);
      if (k == nb - 1) dq.push_back(cyc + 2);
    end
    tick();
    bus.ddr1_valid = 1'b0;
    bus.ddr2_valid = 1'b0;
  endtask

  task automatic scramble_conf();
    bus.conf_mode      = 3'($urandom);
    bus.conf_trans_num = 8'($urandom);
    bus.conf_ch_num    = CH_W'($urandom);
    bus.conf_pix_num   = PIX_W'($urandom);
    bus.conf_row_num   = ROW_W'($urandom);
  endtask

  task automatic start_xfer(input logic [2:0] mode, input int tn, input int cn, input int pn, input int rn);
    bus.conf_mode      = mode;
    bus.conf_trans_num = 8'(tn);
    bus.conf_ch_num    = CH_W'(cn);
    bus.conf_pix_num   = PIX_W'(pn);
    bus.conf_row_num   = ROW_W'(rn);
    bus.start = 1'b1;
    if (mode > 3'd2) dq.push_back(cyc + 1);
    tick();
    bus.start = 1'b0;
    scramble_conf();
  endtask

  task automatic xfer(input logic [2:0] mode, input int tn, input int cn, input int pn, input int rn,
                      input bit gaps, input bit poke);
    int nb, d0, g;
    d0 = done_cnt;
    start_xfer(mode, tn, cn, pn, rn);
    if (mode <= 3'd2) begin
      nb = (mode == 3'd2) ? (cn + 1) * (pn + 1) * (rn + 1) : tn + 1;
      for (int k = 0; k < nb; k++) begin
        g = gaps ? $urandom_range(0, 2) : 0;
        repeat (g) begin
          noise(mode);
          tick();
        end
        if (poke && k == nb / 2 && k > 0) begin
          scramble_conf();
          bus.start = 1'b1;
          err_exp |= ERR_EN;
          tick();
          bus.start = 1'b0;
        end
        drive_beat(mode, k, cn, pn, nb, 1'b1);
      end
      bus.ddr1_valid = 1'b0;
      bus.ddr2_valid = 1'b0;
    end
    for (int i = 0; i < 12 && done_cnt == d0; i++) tick();
    chk("done_seen", 64'(done_cnt != d0), 64'd1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish by 500us");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] md;
    bus.start = 1'b0;
    bus.ddr1_valid = 1'b0;
    bus.ddr2_valid = 1'b0;
    bus.ddr1_data = '0;
    bus.ddr2_data = '0;
    scramble_conf();

    repeat (3) tick();
    chk("rst_wr_en", 64'(bus.pbuf_wr_en), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_addr3", 64'(bus.pbuf_wr_addr[3]), 64'd0);
    chk("rst_data0", bus.pbuf_wr_data[0], 64'd0);
    rst = 1'b1;
    tick();

    xfer(3'd0, 3, 0, 0, 0, 1'b0, 1'b0);

    // Stray beats on the FWD stream while idle: dropped, flagged only with the error option.
    repeat (3) begin
      bus.ddr2_valid = 1'b1;
      bus.ddr2_data  = {$urandom, $urandom};
      tick();
    end
    bus.ddr2_valid = 1'b0;
    err_exp |= ERR_EN;
    tick();
    chk("err_idle_valid", 64'(bus.err), 64'(err_exp));

    xfer(3'd1, 7, 0, 0, 0, 1'b1, 1'b1);
    chk("err_start_run", 64'(bus.err), 64'(err_exp));

    xfer(3'd2, 0, 1, 3, 1, 1'b1, 1'b0);

    // Abort a UPD transfer with beat 4's write on the port.
    start_xfer(3'd2, 0, 1, 3, 1);
    for (int k = 0; k < 5; k++) drive_beat(3'd2, k, 1, 3, 16, k < 4);
    rst = 1'b0;
    #1;
    chk("abort_wr_en", 64'(bus.pbuf_wr_en), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    m_addr  = '0;
    m_data  = '0;
    err_exp = 1'b0;
    tick();
    tick();
    chk("abort_err", 64'(bus.err), 64'd0);
    chk("abort_addr0", 64'(bus.pbuf_wr_addr[0]), 64'd0);
    rst = 1'b1;
    tick();

    xfer(3'd2, 0, 1, 3, 1, 1'b0, 1'b0);
    xfer(3'd5, 0, 0, 0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      md = 3'($urandom_range(0, 3));
      if (md == 3'd3) md = 3'($urandom_range(3, 7));
      xfer(md, $urandom_range(0, 20), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)));
    end

    repeat (4) tick();
    chk("wq_drained", 64'(wq.size()), 64'd0);
    chk("dq_drained", 64'(dq.size()), 64'd0);
    chk("err_final", 64'(bus.err), 64'(err_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
